// File: rtl/clk_gen_ctrl.sv
// Programmable clock divider (/2, /4, /8, /16) with a registered, glitch-free output.
// Divisor changes while running are deferred to the end of the current period.
module clk_gen_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] div_sel,
    input  logic       sel_valid,
    output logic       sel_ready,
    output logic       clk_out,
    output logic       tick,
    output logic [1:0] cur_div,
    output logic       active
);

    typedef enum logic [1:0] {StIdle, StRun, StPend} state_e;

    state_e     r_state;
    logic [3:0] r_cnt;
    logic       r_clk_out;
    logic       r_tick;
    logic [1:0] r_cur_div;
    logic [1:0] r_pend_div;

    state_e     w_state_nxt;
    logic [3:0] w_cnt_nxt;
    logic       w_clk_nxt;
    logic       w_tick_nxt;
    logic [1:0] w_cur_div_nxt;
    logic [1:0] w_pend_div_nxt;

    logic [4:0] w_period;
    logic [4:0] w_half;
    logic [3:0] w_cnt_inc;
    logic       w_last;
    logic       w_clk_inc;
    logic       w_xfer;

    assign w_period  = 5'd2 << r_cur_div;
    assign w_half    = 5'd1 << r_cur_div;
    assign w_cnt_inc = r_cnt + 4'd1;
    assign w_last    = ({1'b0, r_cnt} == (w_period - 5'd1));
    assign w_clk_inc = ({1'b0, w_cnt_inc} < w_half);
    assign w_xfer    = sel_valid & sel_ready;

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_clk_nxt      = r_clk_out;
        w_tick_nxt     = 1'b0;
        w_cur_div_nxt  = r_cur_div;
        w_pend_div_nxt = r_pend_div;

        case (r_state)
            StIdle: begin
                w_cnt_nxt = 4'd0;
                w_clk_nxt = 1'b0;
                if (w_xfer) begin
                    w_cur_div_nxt = div_sel;
                end
                if (en) begin
                    w_state_nxt = StRun;
                    w_clk_nxt   = 1'b1;
                    w_tick_nxt  = 1'b1;
                end
            end
            StRun, StPend: begin
                if (!w_last) begin
                    w_cnt_nxt = w_cnt_inc;
                    w_clk_nxt = w_clk_inc;
                    if (r_state == StRun && w_xfer) begin
                        w_pend_div_nxt = div_sel;
                        w_state_nxt    = StPend;
                    end
                end else begin
                    // Period boundary: the only point where the divisor may change.
                    w_cnt_nxt = 4'd0;
                    if (r_state == StPend) begin
                        w_cur_div_nxt = r_pend_div;
                    end
                    if (en) begin
                        w_clk_nxt   = 1'b1;
                        w_tick_nxt  = 1'b1;
                        w_state_nxt = StRun;
                        if (r_state == StRun && w_xfer) begin
                            w_pend_div_nxt = div_sel;
                            w_state_nxt    = StPend;
                        end
                    end else begin
                        w_clk_nxt   = 1'b0;
                        w_state_nxt = StIdle;
                        if (r_state == StRun && w_xfer) begin
                            w_cur_div_nxt = div_sel;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = StIdle;
                w_cnt_nxt   = 4'd0;
                w_clk_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= StIdle;
            r_cnt      <= 4'd0;
            r_clk_out  <= 1'b0;
            r_tick     <= 1'b0;
            r_cur_div  <= 2'd0;
            r_pend_div <= 2'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_clk_out  <= w_clk_nxt;
            r_tick     <= w_tick_nxt;
            r_cur_div  <= w_cur_div_nxt;
            r_pend_div <= w_pend_div_nxt;
        end
    end

    assign sel_ready = (r_state != StPend);
    assign active    = (r_state != StIdle);
    assign clk_out   = r_clk_out;
    assign tick      = r_tick;
    assign cur_div   = r_cur_div;

endmodule

// File: tb/tb_clk_gen_ctrl.sv
// Directed-vector bench for clk_gen_ctrl: stimulus queues expected post-edge outputs,
// a monitor pops and compares them one cycle at a time.
module tb_clk_gen_ctrl;

    logic       clk;
    logic       reset;
    logic       en;
    logic [1:0] div_sel;
    logic       sel_valid;
    logic       sel_ready;
    logic       clk_out;
    logic       tick;
    logic [1:0] cur_div;
    logic       active;

    typedef struct {
        logic [5:0] v;
        string      name;
    } exp_t;

    exp_t  exp_q[$];
    int    n_vec;
    int    n_err;
    string phase;

    clk_gen_ctrl u_dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .div_sel   (div_sel),
        .sel_valid (sel_valid),
        .sel_ready (sel_ready),
        .clk_out   (clk_out),
        .tick      (tick),
        .cur_div   (cur_div),
        .active    (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic step(input logic r, input logic e, input logic sv, input logic [1:0] ds,
                        input logic ec, input logic et, input logic [1:0] ed,
                        input logic ea, input logic er);
        exp_t x;
        @(negedge clk);
        reset     = r;
        en        = e;
        sel_valid = sv;
        div_sel   = ds;
        x.v       = {ec, et, ed, ea, er};
        x.name    = phase;
        exp_q.push_back(x);
    endtask

    initial begin : monitor
        exp_t       x;
        logic [5:0] got;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x   = exp_q.pop_front();
                got = {clk_out, tick, cur_div, active, sel_ready};
                n_vec++;
                if (got !== x.v) begin
                    n_err++;
                    $display("FAIL %s vec%0d: got clk_out=%b tick=%b cur_div=%0d active=%b sel_ready=%b, want clk_out=%b tick=%b cur_div=%0d active=%b sel_ready=%b",
                             x.name, n_vec, got[5], got[4], got[3:2], got[1], got[0],
                             x.v[5], x.v[4], x.v[3:2], x.v[1], x.v[0]);
                end
            end
        end
    end

    initial begin : stimulus
        n_vec     = 0;
        n_err     = 0;
        reset     = 1'b1;
        en        = 1'b0;
        sel_valid = 1'b0;
        div_sel   = 2'd0;

        // Reset wins over en and sel_valid.
        phase = "reset";
        repeat (2) step(1, 1, 1, 2'd3, 0, 0, 2'd0, 0, 1);

        phase = "div2";
        for (int i = 0; i < 6; i++) step(0, 1, 0, 2'd0, (i % 2 == 0), (i % 2 == 0), 2'd0, 1, 1);
        step(0, 0, 0, 2'd0, 0, 0, 2'd0, 0, 1);

        phase = "idle_sel";
        step(0, 0, 1, 2'd2, 0, 0, 2'd2, 0, 1);

        phase = "div8";
        for (int i = 0; i < 17; i++)
            step(0, 1, 0, 2'd0, ((i % 8) < 4), ((i % 8) == 0), 2'd2, 1, 1);

        // Change /8 -> /4 at cnt=0; requests held during PEND must be ignored.
        phase = "pend8to4";
        step(0, 1, 1, 2'd1, 1, 0, 2'd2, 1, 0);
        step(0, 1, 1, 2'd3, 1, 0, 2'd2, 1, 0);
        step(0, 1, 1, 2'd3, 1, 0, 2'd2, 1, 0);
        for (int i = 4; i < 8; i++) step(0, 1, 0, 2'd0, 0, 0, 2'd2, 1, 0);
        step(0, 1, 0, 2'd0, 1, 1, 2'd1, 1, 1);

        phase = "pend4to2";
        step(0, 1, 0, 2'd0, 1, 0, 2'd1, 1, 1);
        step(0, 1, 1, 2'd0, 0, 0, 2'd1, 1, 0);
        step(0, 1, 0, 2'd0, 0, 0, 2'd1, 1, 0);
        step(0, 1, 0, 2'd0, 1, 1, 2'd0, 1, 1);
        step(0, 1, 0, 2'd0, 0, 0, 2'd0, 1, 1);
        step(0, 1, 0, 2'd0, 1, 1, 2'd0, 1, 1);
        step(0, 1, 0, 2'd0, 0, 0, 2'd0, 1, 1);
        step(0, 0, 0, 2'd0, 0, 0, 2'd0, 0, 1);

        // Start with simultaneous transfer; en dips mid-period, later drops at cnt=5.
        phase = "div16";
        step(0, 1, 1, 2'd3, 1, 1, 2'd3, 1, 1);
        for (int k = 1; k < 32; k++)
            step(0, !((k >= 5 && k <= 10) || k >= 22), 0, 2'd0,
                 ((k % 16) < 8), ((k % 16) == 0), 2'd3, 1, 1);
        step(0, 0, 0, 2'd0, 0, 0, 2'd3, 0, 1);

        phase = "pend_reset";
        step(0, 0, 1, 2'd1, 0, 0, 2'd1, 0, 1);
        step(0, 1, 0, 2'd0, 1, 1, 2'd1, 1, 1);
        step(0, 1, 1, 2'd3, 1, 0, 2'd1, 1, 0);
        step(0, 1, 0, 2'd0, 0, 0, 2'd1, 1, 0);
        step(1, 1, 1, 2'd2, 0, 0, 2'd0, 0, 1);

        phase = "after_reset";
        for (int i = 0; i < 6; i++) step(0, 1, 0, 2'd0, (i % 2 == 0), (i % 2 == 0), 2'd0, 1, 1);
        step(1, 0, 0, 2'd0, 0, 0, 2'd0, 0, 1);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            n_err++;
            $display("FAIL drain: %0d expected vectors still queued, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
